// File: rtl/register16.sv
// rtl/register16.sv - WIDTH-bit load-enabled register with synchronous active-low reset
// Tracks whether any load has happened since the last reset.
module register16 #(
  parameter int          WIDTH       = 16,
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             loaded
);

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  // Reset is tested first so an unknown load cannot leak into the reset value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out    <= RST_VAL;
      loaded <= 1'b0;
    end else if (load) begin
      out    <= in;
      loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_register16.sv
// tb/tb_register16.sv - scoreboard bench for register16 at default and 8-bit widths
module tb_register16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, loaded_d;
  logic [15:0] in_d, out_d;
  logic        rst8, load8, loaded8;
  logic [7:0]  in8, out8;

  register16 dut (
    .clk(clk), .rst(rst), .load(load), .in(in_d), .out(out_d), .loaded(loaded_d)
  );

  register16 #(.WIDTH(8), .RESET_VALUE(64'h3C)) dut8 (
    .clk(clk), .rst(rst8), .load(load8), .in(in8), .out(out8), .loaded(loaded8)
  );

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  logic [8:0]  exp8_q[$];
  logic [15:0] m_out;
  logic        m_loaded;
  logic [7:0]  m8_out;
  logic        m8_loaded;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input string tag, input logic r, input logic l, input logic [15:0] d);
    logic [16:0] e;
    @(negedge clk);
    rst = r; load = l; in_d = d;
    if (!r) begin
      m_out = 16'd0; m_loaded = 1'b0;
    end else if (l) begin
      m_out = d; m_loaded = 1'b1;
    end
    exp_q.push_back({m_loaded, m_out});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_out"}, 64'(out_d), 64'(e[15:0]));
      check_val({tag, "_loaded"}, 64'(loaded_d), 64'(e[16]));
    end
  endtask

  task automatic drive8(input string tag, input logic r, input logic l, input logic [7:0] d);
    logic [8:0] e;
    @(negedge clk);
    rst8 = r; load8 = l; in8 = d;
    if (!r) begin
      m8_out = 8'h3C; m8_loaded = 1'b0;
    end else if (l) begin
      m8_out = d; m8_loaded = 1'b1;
    end
    exp8_q.push_back({m8_loaded, m8_out});
    @(posedge clk);
    #1;
    if (exp8_q.size() == 0) begin
      check_val({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp8_q.pop_front();
      check_val({tag, "_out"}, 64'(out8), 64'(e[7:0]));
      check_val({tag, "_loaded"}, 64'(loaded8), 64'(e[8]));
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; in_d = 16'd0;
    rst8 = 1'b1; load8 = 1'b0; in8 = 8'd0;
    m_out = 16'd0; m_loaded = 1'b0;
    m8_out = 8'h3C; m8_loaded = 1'b0;

    drive("reset_x", 1'b0, 1'bx, 16'hxxxx);
    check_val("reset_const", 64'(out_d), 64'd0);

    drive("load123", 1'b1, 1'b1, 16'd123);
    for (int i = 0; i < 3; i++) drive("hold123", 1'b1, 1'b0, 16'd0);
    check_val("hold_const", 64'(out_d), 64'd123);

    drive("b2b_ffff", 1'b1, 1'b1, 16'hFFFF);
    drive("b2b_0000", 1'b1, 1'b1, 16'h0000);
    drive("b2b_a5a5", 1'b1, 1'b1, 16'hA5A5);
    check_val("b2b_const", 64'(out_d), 64'hA5A5);
    drive("same_val", 1'b1, 1'b1, 16'hA5A5);

    drive("reload123", 1'b1, 1'b1, 16'd123);
    drive("rst_prio", 1'b0, 1'b1, 16'h5555);
    check_val("rst_prio_const", 64'({loaded_d, out_d}), 64'd0);

    drive("pre_glitch", 1'b1, 1'b1, 16'h1234);
    #2;
    rst = 1'b0; load = 1'b1; in_d = 16'hFFFF;
    #1;
    check_val("glitch_mid_out", 64'(out_d), 64'h1234);
    check_val("glitch_mid_loaded", 64'(loaded_d), 64'd1);
    rst = 1'b1; load = 1'b0; in_d = 16'd0;
    drive("post_glitch", 1'b1, 1'b0, 16'hBEEF);
    check_val("glitch_const", 64'(out_d), 64'h1234);

    for (int i = 0; i < 24; i++) begin
      drive("random", ($urandom_range(0, 7) != 0), 1'($urandom), 16'($urandom));
    end

    drive8("w8_reset", 1'b0, 1'b1, 8'hFF);
    check_val("w8_reset_const", 64'(out8), 64'h3C);
    drive8("w8_load", 1'b1, 1'b1, 8'hC3);
    check_val("w8_load_const", 64'(out8), 64'hC3);
    drive8("w8_hold", 1'b1, 1'b0, 8'h00);
    drive8("w8_rst_again", 1'b0, 1'b0, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register16.md
REGISTER16 -- requirements
Module: register16

Interface
REQ-001 Parameter: WIDTH, default 16, data width in bits; legal range 1..64.
REQ-002 Parameter: RESET_VALUE, default 0, value loaded into out on reset; truncated to WIDTH bits.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge only.
REQ-004 Port: rst  input  1  synchronous, active-low reset (0 = reset asserted); sampled on the rising edge of clk.
REQ-005 Port: load  input  1  write enable; active-high.
REQ-006 Port: in  input  WIDTH  data to be stored.
REQ-007 Port: out  output  WIDTH  stored value; driven directly from the storage flops, with no combinational path from in or load.
REQ-008 Port: loaded  output  1  high when at least one load has occurred since the last reset; may be left unconnected.

Function
REQ-009 On each rising clk edge with rst=0, out SHALL become RESET_VALUE and loaded SHALL become 0, regardless of load and in.
REQ-010 On each rising clk edge with rst=1 and load=1, out SHALL become the value of in sampled at that edge, and loaded SHALL become 1.
REQ-011 On each rising clk edge with rst=1 and load=0, out and loaded SHALL hold their previous values.
REQ-012 Load latency SHALL be one cycle: a value presented with load=1 at edge N SHALL be visible on out after edge N and remain stable until the next qualifying edge.
REQ-013 Changes on in, load or rst between clock edges SHALL NOT affect out or loaded.
REQ-014 Reset SHALL take priority over load when both are asserted at the same edge.
REQ-015 If load is X or Z while rst=0, the register SHALL still reset cleanly to RESET_VALUE, with no X on out.
REQ-016 Consecutive loads on back-to-back cycles SHALL each take effect, with the last one winning; no wait states.
REQ-017 Loading the same value as the one already stored SHALL leave out unchanged and SHALL set loaded=1.
REQ-018 All WIDTH bits SHALL load and reset independently, with no masking, sign extension or arithmetic applied.

Reset
REQ-019 Before the first reset edge, out is unspecified; after one rising edge with rst=0, out = RESET_VALUE and loaded = 0.
REQ-020 A reset asserted mid-operation, after any number of loads, SHALL clear out to RESET_VALUE and loaded to 0 on the next rising edge.
REQ-021 Reset SHALL have no asynchronous effect: asserting rst=0 between edges SHALL leave out unchanged until the next rising edge.

Verification
REQ-022 rst=0 for one edge with load=X and in=X -> out = 16'd0, loaded = 0.
REQ-023 rst=1, load=1, in=16'd123 at an edge -> out = 16'd123 after that edge, loaded = 1; then load=0 and in=16'd0 for 3 edges -> out stays 16'd123.
REQ-024 rst=1, load=1, in = 16'hFFFF, 16'h0000, 16'hA5A5 on 3 consecutive edges -> out follows each value one edge later; final out = 16'hA5A5.
REQ-025 After out = 16'd123, set rst=0 and load=1 with in=16'h5555 at the same edge -> out = 16'd0, loaded = 0.
REQ-026 Toggle in and load, and drop rst=0, mid-period, then restore rst=1 before the next edge -> out unchanged between edges; only edge-sampled values take effect.
REQ-027 WIDTH=8, RESET_VALUE=8'h3C: reset -> out = 8'h3C; load 8'hC3 -> out = 8'hC3.
